// File: rtl/degree_entry_ctrl.sv
// Keypad sequencer for the BCD-to-binary degree converter: collects up to three
// digits, waits out the converter latency on ENTER and publishes a range-checked angle.
module degree_entry_ctrl #(
    parameter int unsigned CONV_LAT    = 2,
    parameter int unsigned MAX_DEG     = 180,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    output logic [3:0] o_units,
    output logic [3:0] o_tens,
    output logic [3:0] o_hundreds,
    input  logic [8:0] i_degrees,
    output logic [1:0] o_digit_count,
    output logic       o_busy,
    output logic [8:0] o_deg,
    output logic       o_deg_valid,
    output logic       o_err,
    output logic       o_timeout
);

    localparam int unsigned LW = $clog2(CONV_LAT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_CONV  = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    units_q;
    logic [3:0]    tens_q;
    logic [3:0]    hundreds_q;
    logic [1:0]    count_q;
    logic [LW-1:0] lat_q;
    logic [TW-1:0] tmr_q;
    logic          busy_q;
    logic [8:0]    deg_q;
    logic          deg_valid_q;
    logic          err_q;
    logic          timeout_q;

    // Key decode; a fourth digit is not a usable key and leaves the timer running.
    logic is_digit_c;
    logic is_clear_c;
    logic is_enter_c;
    logic digit_ok_c;

    always_comb begin
        is_digit_c = i_key_valid && (i_key_code <= 4'd9);
        is_clear_c = i_key_valid && (i_key_code == 4'hA);
        is_enter_c = i_key_valid && (i_key_code == 4'hB);
        digit_ok_c = is_digit_c && (count_q != 2'd3);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            hundreds_q  <= 4'd0;
            count_q     <= 2'd0;
            lat_q       <= '0;
            tmr_q       <= '0;
            busy_q      <= 1'b0;
            deg_q       <= 9'd0;
            deg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            deg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (digit_ok_c) begin
                        hundreds_q <= tens_q;
                        tens_q     <= units_q;
                        units_q    <= i_key_code;
                        count_q    <= count_q + 2'd1;
                        tmr_q      <= TW'(TIMEOUT_CYC - 1);
                        state_q    <= S_ENTRY;
                    end else if (is_clear_c) begin
                        units_q    <= 4'd0;
                        tens_q     <= 4'd0;
                        hundreds_q <= 4'd0;
                        count_q    <= 2'd0;
                        state_q    <= S_IDLE;
                    end else if (is_enter_c) begin
                        if (count_q == 2'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            lat_q   <= LW'(CONV_LAT);
                            busy_q  <= 1'b1;
                            state_q <= S_CONV;
                        end
                    end else if (state_q == S_ENTRY) begin
                        // Idle in ENTRY: count down and discard the partial entry on expiry.
                        if (tmr_q == '0) begin
                            units_q    <= 4'd0;
                            tens_q     <= 4'd0;
                            hundreds_q <= 4'd0;
                            count_q    <= 2'd0;
                            timeout_q  <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            tmr_q <= tmr_q - TW'(1);
                        end
                    end
                end
                S_CONV: begin
                    if (lat_q == '0) begin
                        if (i_degrees <= 9'(MAX_DEG)) begin
                            deg_q       <= i_degrees;
                            deg_valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        units_q    <= 4'd0;
                        tens_q     <= 4'd0;
                        hundreds_q <= 4'd0;
                        count_q    <= 2'd0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_units       = units_q;
    assign o_tens        = tens_q;
    assign o_hundreds    = hundreds_q;
    assign o_digit_count = count_q;
    assign o_busy        = busy_q;
    assign o_deg         = deg_q;
    assign o_deg_valid   = deg_valid_q;
    assign o_err         = err_q;
    assign o_timeout     = timeout_q;

endmodule
